conv_kxk: RTL
=============

CONV_KXK -- requirements
Module: conv_kxk

Interface
REQ-001 Parameter INTEGER_BITS, default 8, signed integer bits of every sample, weight and result.
REQ-002 Parameter FIXED_POINT_BITS, default 4, fractional bits; W = INTEGER_BITS+FIXED_POINT_BITS.
REQ-003 Parameter KSIZE, default 3, kernel edge (legal 1..7); N = KSIZE*KSIZE taps.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_pixel_data  in  W*N  window; tap t at bits [t*W +: W].
REQ-008 i_pixel_data_valid  in  1  window valid.
REQ-009 o_pixel_data_ready  out  1  window accepted when valid&&ready.
REQ-010 i_kernel_wr  in  1  weight write strobe.
REQ-011 i_kernel_addr  in  clog2(N) (min 1)  tap index.
REQ-012 i_kernel_data  in  W  weight value.
REQ-013 o_convolved_data  out  W  result.
REQ-014 o_convolved_data_valid  out  1  result valid.
REQ-015 i_convolved_data_ready  in  1  downstream ready.
REQ-016 o_sat_flag  out  1  sticky saturation indicator.
REQ-017 i_sat_clr  in  1  clears o_sat_flag.

Function
REQ-018 All samples/weights SHALL be two's-complement signed fixed point, FIXED_POINT_BITS fractional.
REQ-019 Stage 1 SHALL register N full-precision 2W-bit signed products weight[t]*pixel[t].
REQ-020 Stage 2 SHALL register the signed sum of products in ACC_W = 2W+clog2(N) bits, no overflow.
REQ-021 Stage 3 SHALL add 2^(FIXED_POINT_BITS-1) (round half up), arithmetic-shift right FIXED_POINT_BITS, saturate to W-bit signed range, register into o_convolved_data.
REQ-022 Latency SHALL be 3 cycles from acceptance to o_convolved_data_valid when unstalled; throughput one window per cycle.
REQ-023 Pipeline advance enable SHALL be (!o_convolved_data_valid || i_convolved_data_ready); o_pixel_data_ready SHALL equal it combinationally.
REQ-024 When stalled, all stages, output data and valid SHALL hold unchanged; bubbles are not compressed.
REQ-025 Per-stage valid bits SHALL propagate with data; invalid stages carry don't-care data.
REQ-026 Kernel write SHALL update weight[i_kernel_addr] at the clock edge; a window accepted in the same cycle uses the old weight.
REQ-027 Writes with i_kernel_addr >= N SHALL be ignored; writes are accepted regardless of stall.
REQ-028 o_sat_flag SHALL set when a stage-3 result saturates and is loaded; set has priority over simultaneous i_sat_clr.

Reset
REQ-029 On i_rst_n low: all stage valids, o_convolved_data_valid, o_convolved_data, o_sat_flag SHALL be 0; in-flight data discarded.
REQ-030 On reset every weight SHALL be 1.0 (value 2^FIXED_POINT_BITS).
REQ-031 o_pixel_data_ready SHALL read 1 during and immediately after reset.

Configuration
REQ-032 Macro CONV_RELU_EN defined: stage 3 SHALL clamp negative results to 0 after saturation; o_sat_flag unaffected by the clamp.
REQ-033 CONV_RELU_EN undefined: signed results SHALL be output unchanged.

Structure
REQ-034 Package conv_pkg SHALL hold default INTEGER_BITS/FIXED_POINT_BITS, the acc-width and saturation-limit helper functions.
REQ-035 Sub-module conv_adder_tree (parametrised N, input width) SHALL implement the stage-2 sum.

Verification (KSIZE=3, W=12, F=4)
REQ-036 Reset weights, all pixels 0x010 (1.0) -> 0x090 (9.0) valid exactly 3 cycles later.
REQ-037 All pixels 0x640 (100.0), weights 1.0 -> 0x7FF, o_sat_flag=1; i_sat_clr -> flag 0.
REQ-038 All pixels 0xFE0 (-2.0) -> 0xEE0 (-18.0); with CONV_RELU_EN -> 0x000.
REQ-039 Weights tap0=0x008, others 0; pixel tap0=0x001 -> 0x001 (rounding up).
REQ-040 Stream 5 windows, hold i_convolved_data_ready low 4 cycles -> output held stable, o_pixel_data_ready low, no window lost or duplicated.
REQ-041 Assert i_rst_n low with 3 windows in flight -> valid 0 next edge, no stale output after release.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg -- shared defaults and width/saturation helpers for the KxK convolution.
// Rev 1.0
`default_nettype none

package conv_pkg;

  localparam int DEF_INTEGER_BITS     = 8;
  localparam int DEF_FIXED_POINT_BITS = 4;

  // Headroom for summing n full-precision products of two w-bit operands.
  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_adder_tree.sv
// conv_adder_tree -- signed sum of N packed IN_W-bit terms into OUT_W bits.
// Rev 1.0
`default_nettype none

module conv_adder_tree #(
  parameter int N     = 9,
  parameter int IN_W  = 24,
  parameter int OUT_W = 28
) (
  input  logic [N*IN_W-1:0]       terms,
  output logic signed [OUT_W-1:0] sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + OUT_W'($signed(terms[i*IN_W +: IN_W]));
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_kxk.sv
// conv_kxk -- KxK fixed-point convolution, 3-stage multiply/sum/round-saturate pipeline.
// Rev 1.0. Optional macro CONV_RELU_EN clamps negative results to zero.
`default_nettype none

module conv_kxk
  import conv_pkg::*;
#(
  parameter int  INTEGER_BITS     = DEF_INTEGER_BITS,
  parameter int  FIXED_POINT_BITS = DEF_FIXED_POINT_BITS,
  parameter int  KSIZE            = 3,
  localparam int W                = INTEGER_BITS + FIXED_POINT_BITS,
  localparam int N                = KSIZE * KSIZE,
  localparam int AW               = addr_width(N)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [W*N-1:0] i_pixel_data,
  input  logic           i_pixel_data_valid,
  output logic           o_pixel_data_ready,
  input  logic           i_kernel_wr,
  input  logic [AW-1:0]  i_kernel_addr,
  input  logic [W-1:0]   i_kernel_data,
  output logic [W-1:0]   o_convolved_data,
  output logic           o_convolved_data_valid,
  input  logic           i_convolved_data_ready,
  output logic           o_sat_flag,
  input  logic           i_sat_clr
);

  localparam int PW    = 2 * W;
  localparam int ACC_W = acc_width(W, N);
  localparam int RW    = ACC_W + 1;

  localparam logic signed [RW-1:0] ROUND  = RW'((64'sd1 <<< FIXED_POINT_BITS) >>> 1);
  localparam logic signed [RW-1:0] SAT_HI = RW'(sat_max(W));
  localparam logic signed [RW-1:0] SAT_LO = RW'(sat_min(W));
  localparam logic signed [W-1:0]  ONE    = W'(64'sd1 <<< FIXED_POINT_BITS);

  logic signed [W-1:0]     weight [N];
  logic [N*PW-1:0]         prod;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc;
  logic signed [RW-1:0]    rounded;
  logic signed [RW-1:0]    shifted;
  logic signed [W-1:0]     result;
  logic                    sat;
  logic                    v1;
  logic                    v2;
  logic                    advance;

  assign advance            = !o_convolved_data_valid || i_convolved_data_ready;
  assign o_pixel_data_ready = advance;

  // Weight writes ignore the stall so software can reload the kernel at any time.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int t = 0; t < N; t++) begin
        weight[t] <= ONE;
      end
    end else if (i_kernel_wr && (32'(i_kernel_addr) < N)) begin
      weight[i_kernel_addr] <= i_kernel_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (advance) begin
      for (int t = 0; t < N; t++) begin
        prod[t*PW +: PW] <= PW'(weight[t]) * PW'($signed(i_pixel_data[t*W +: W]));
      end
      acc <= sum;
    end
  end

  conv_adder_tree #(
    .N     (N),
    .IN_W  (PW),
    .OUT_W (ACC_W)
  ) u_adder_tree (
    .terms (prod),
    .sum   (sum)
  );

  always_comb begin
    rounded = RW'(acc) + ROUND;
    shifted = rounded >>> FIXED_POINT_BITS;
    sat     = 1'b0;
    result  = shifted[W-1:0];
    if (shifted > SAT_HI) begin
      result = SAT_HI[W-1:0];
      sat    = 1'b1;
    end else if (shifted < SAT_LO) begin
      result = SAT_LO[W-1:0];
      sat    = 1'b1;
    end
`ifdef CONV_RELU_EN
    if (result[W-1]) begin
      result = '0;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1                     <= 1'b0;
      v2                     <= 1'b0;
      o_convolved_data_valid <= 1'b0;
      o_convolved_data       <= '0;
      o_sat_flag             <= 1'b0;
    end else begin
      if (advance) begin
        v1                     <= i_pixel_data_valid;
        v2                     <= v1;
        o_convolved_data_valid <= v2;
        if (v2) begin
          o_convolved_data <= result;
        end
      end
      // A saturating load wins over a clear in the same cycle.
      if (advance && v2 && sat) begin
        o_sat_flag <= 1'b1;
      end else if (i_sat_clr) begin
        o_sat_flag <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
